ball_engine: RTL and testbench

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine.sv | 217 +++++++++++++++++++++
 tb/tb_ball_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ball_engine
//  Description : Pong ball motion, paddle bounce, scoring and game FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_engine #(
    parameter int XSCREEN    = 160,
    parameter int YSCREEN    = 120,
    parameter int X0         = 2,
    parameter int PADDLE_W   = 2,
    parameter int PADDLE_LEN = 25,
    parameter int BALL_SIZE  = 5,
    parameter int XW         = 8,
    parameter int YW         = 7,
    parameter int WIN_SCORE  = 9
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          tick,
    input  logic          serve,
    input  logic [YW-1:0] Y1,
    input  logic [YW-1:0] Y2,
    output logic [XW-1:0] X,
    output logic [YW-1:0] Y,
    output logic          dx,
    output logic          dy,
    output logic          hit1,
    output logic          hit2,
    output logic          point,
    output logic [3:0]    score1,
    output logic [3:0]    score2,
    output logic          game_over,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [XW-1:0] c_xc      = XW'((XSCREEN - BALL_SIZE) / 2);
    localparam logic [YW-1:0] c_yc      = YW'((YSCREEN - BALL_SIZE) / 2);
    localparam logic [XW-1:0] c_x_one   = XW'(1);
    localparam logic [YW-1:0] c_y_one   = YW'(1);
    localparam logic [XW-1:0] c_lface   = XW'(X0 + PADDLE_W);
    localparam logic [XW:0]   c_rface   = (XW+1)'(XSCREEN - X0 - PADDLE_W);
    localparam logic [XW:0]   c_xright  = (XW+1)'(XSCREEN);
    localparam logic [XW:0]   c_xball   = (XW+1)'(BALL_SIZE);
    localparam logic [YW:0]   c_ybot    = (YW+1)'(YSCREEN);
    localparam logic [YW:0]   c_yball   = (YW+1)'(BALL_SIZE);
    localparam logic [YW:0]   c_plen    = (YW+1)'(PADDLE_LEN);
    localparam logic [3:0]    c_win     = 4'(WIN_SCORE);

    state_t        r_state, w_state;
    logic [XW-1:0] r_x, w_x;
    logic [YW-1:0] r_y, w_y;
    logic          r_dx, w_dx;
    logic          r_dy, w_dy;
    logic          r_serve_dir, w_serve_dir;
    logic          r_p1_scored, w_p1_scored;
    logic [3:0]    r_score1, w_score1;
    logic [3:0]    r_score2, w_score2;
    logic          r_hit1, w_hit1;
    logic          r_hit2, w_hit2;
    logic          r_point, w_point;
    logic          r_game_over, w_game_over;
    logic          w_score_evt;

    // Extended-width edges so no sum wraps near the top of the coordinate range
    logic [XW:0] w_xr;
    logic [YW:0] w_yb;
    logic        w_ov1, w_ov2;

    assign w_xr  = {1'b0, r_x} + c_xball;
    assign w_yb  = {1'b0, r_y} + c_yball;
    assign w_ov1 = (w_yb > {1'b0, Y1}) && ({1'b0, r_y} < ({1'b0, Y1} + c_plen));
    assign w_ov2 = (w_yb > {1'b0, Y2}) && ({1'b0, r_y} < ({1'b0, Y2} + c_plen));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state     <= ST_IDLE;
            r_x         <= c_xc;
            r_y         <= c_yc;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_serve_dir <= 1'b1;
            r_p1_scored <= 1'b0;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_point     <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_x         <= w_x;
            r_y         <= w_y;
            r_dx        <= w_dx;
            r_dy        <= w_dy;
            r_serve_dir <= w_serve_dir;
            r_p1_scored <= w_p1_scored;
            r_score1    <= w_score1;
            r_score2    <= w_score2;
            r_hit1      <= w_hit1;
            r_hit2      <= w_hit2;
            r_point     <= w_point;
            r_game_over <= w_game_over;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_x         = r_x;
        w_y         = r_y;
        w_dx        = r_dx;
        w_dy        = r_dy;
        w_serve_dir = r_serve_dir;
        w_p1_scored = r_p1_scored;
        w_score1    = r_score1;
        w_score2    = r_score2;
        w_hit1      = 1'b0;
        w_hit2      = 1'b0;
        w_point     = 1'b0;
        w_game_over = r_game_over;
        w_score_evt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (serve) begin
                    w_state = ST_PLAY;
                    w_dx    = r_serve_dir;
                    w_dy    = 1'b1;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (!r_dx && (r_x == c_lface) && w_ov1) begin
                        w_dx   = 1'b1;
                        w_x    = r_x + c_x_one;
                        w_hit1 = 1'b1;
                    end else if (!r_dx && (r_x == '0)) begin
                        w_score_evt = 1'b1;
                        w_p1_scored = 1'b0;
                    end else if (r_dx && (w_xr == c_rface) && w_ov2) begin
                        w_dx   = 1'b0;
                        w_x    = r_x - c_x_one;
                        w_hit2 = 1'b1;
                    end else if (r_dx && (w_xr == c_xright)) begin
                        w_score_evt = 1'b1;
                        w_p1_scored = 1'b1;
                    end else begin
                        w_x = r_dx ? (r_x + c_x_one) : (r_x - c_x_one);
                    end

                    // A score freezes the ball where it left the field
                    if (w_score_evt) begin
                        w_state = ST_POINT;
                        w_x     = r_x;
                    end else if (!r_dy && (r_y == '0)) begin
                        w_dy = 1'b1;
                        w_y  = r_y + c_y_one;
                    end else if (r_dy && (w_yb == c_ybot)) begin
                        w_dy = 1'b0;
                        w_y  = r_y - c_y_one;
                    end else begin
                        w_y = r_dy ? (r_y + c_y_one) : (r_y - c_y_one);
                    end
                end
            end
            ST_POINT: begin
                w_point = 1'b1;
                w_x     = c_xc;
                w_y     = c_yc;
                if (r_p1_scored) begin
                    w_score1    = (r_score1 < c_win) ? (r_score1 + 4'd1) : r_score1;
                    w_serve_dir = 1'b1;
                    w_game_over = (w_score1 == c_win);
                end else begin
                    w_score2    = (r_score2 < c_win) ? (r_score2 + 4'd1) : r_score2;
                    w_serve_dir = 1'b0;
                    w_game_over = (w_score2 == c_win);
                end
                w_state = w_game_over ? ST_OVER : ST_IDLE;
            end
            ST_OVER: begin
                w_x = c_xc;
                w_y = c_yc;
                if (serve) begin
                    w_score1    = 4'd0;
                    w_score2    = 4'd0;
                    w_serve_dir = 1'b1;
                    w_game_over = 1'b0;
                    w_state     = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign X         = r_x;
    assign Y         = r_y;
    assign dx        = r_dx;
    assign dy        = r_dy;
    assign hit1      = r_hit1;
    assign hit2      = r_hit2;
    assign point     = r_point;
    assign score1    = r_score1;
    assign score2    = r_score2;
    assign game_over = r_game_over;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ball_engine
//  Description : Directed self-checking bench for ball_engine (WIN_SCORE=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic [6:0] Y1 = '0;
    logic [6:0] Y2 = '0;
    logic [7:0] X;
    logic [6:0] Y;
    logic       dx, dy, hit1, hit2, point, game_over;
    logic [3:0] score1, score2;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    ball_engine #(.WIN_SCORE(3)) dut (
        .Clock(Clock), .Resetn(Resetn), .tick(tick), .serve(serve),
        .Y1(Y1), .Y2(Y2), .X(X), .Y(Y), .dx(dx), .dy(dy),
        .hit1(hit1), .hit2(hit2), .point(point),
        .score1(score1), .score2(score2), .game_over(game_over), .state(state)
    );

    always #5 Clock = ~Clock;

    // One clock with the given strobes; outputs are sampled 1 ns after the edge
    task automatic clk_cycle(input logic t, input logic s);
        tick  = t;
        serve = s;
        @(posedge Clock);
        #1;
        tick  = 1'b0;
        serve = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) clk_cycle(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clock);
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (X !== 8'd77) begin bad++; $display("FAIL reset_x got=%0d exp=77", X); end
        total++; if (Y !== 7'd57) begin bad++; $display("FAIL reset_y got=%0d exp=57", Y); end
        total++; if ({dx, dy} !== 2'b11) begin bad++; $display("FAIL reset_dir got=%b exp=11", {dx, dy}); end
        total++; if ({score1, score2} !== 8'h00) begin bad++; $display("FAIL reset_scores got=%h exp=00", {score1, score2}); end
        total++; if ({hit1, hit2, point, game_over} !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {hit1, hit2, point, game_over}); end
        Resetn = 1'b1;
    endtask

    task automatic test_serve;
        clk_cycle(1'b1, 1'b1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL serve_state got=%0d exp=1", state); end
        total++; if ({X, Y} !== {8'd77, 7'd57}) begin bad++; $display("FAIL serve_nomove got=(%0d,%0d) exp=(77,57)", X, Y); end
        clk_cycle(1'b1, 1'b0);
        total++; if ({X, Y} !== {8'd78, 7'd58}) begin bad++; $display("FAIL first_tick got=(%0d,%0d) exp=(78,58)", X, Y); end
        clk_cycle(1'b0, 1'b0);
        total++; if ({X, Y} !== {8'd78, 7'd58}) begin bad++; $display("FAIL no_tick_hold got=(%0d,%0d) exp=(78,58)", X, Y); end
        clk_cycle(1'b0, 1'b1);
        total++; if (state !== 2'd1 || X !== 8'd78) begin bad++; $display("FAIL serve_in_play got=state%0d x%0d exp=state1 x78", state, X); end
    endtask

    task automatic test_reset_mid_play;
        ticks(3);
        total++; if ({X, Y} !== {8'd81, 7'd61}) begin bad++; $display("FAIL pre_reset_pos got=(%0d,%0d) exp=(81,61)", X, Y); end
        #2 Resetn = 1'b0;
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL async_reset_state got=%0d exp=0", state); end
        total++; if ({X, Y} !== {8'd77, 7'd57}) begin bad++; $display("FAIL async_reset_pos got=(%0d,%0d) exp=(77,57)", X, Y); end
        total++; if ({dx, dy, score1, score2} !== 10'b11_0000_0000) begin bad++; $display("FAIL async_reset_misc got=%b exp=1100000000", {dx, dy, score1, score2}); end
        @(posedge Clock);
        #1 Resetn = 1'b1;
        clk_cycle(1'b0, 1'b1);
        total++; if (state !== 2'd1 || dx !== 1'b1) begin bad++; $display("FAIL first_edge_after_reset got=state%0d dx%0d exp=state1 dx1", state, dx); end
    endtask

    task automatic test_wall_bounce;
        Y1 = 7'd0;
        Y2 = 7'd0;
        ticks(58);
        total++; if ({X, Y, dy} !== {8'd135, 7'd115, 1'b1}) begin bad++; $display("FAIL approach_bottom got=(%0d,%0d,dy%0d) exp=(135,115,dy1)", X, Y, dy); end
        ticks(1);
        total++; if ({X, Y, dy} !== {8'd136, 7'd114, 1'b0}) begin bad++; $display("FAIL bottom_bounce got=(%0d,%0d,dy%0d) exp=(136,114,dy0)", X, Y, dy); end
        total++; if ({hit1, hit2} !== 2'b00) begin bad++; $display("FAIL bottom_no_hit got=%b exp=00", {hit1, hit2}); end
    endtask

    task automatic test_hit2;
        Y2 = 7'd75;  // Y=99 is the last row still under Y2+PADDLE_LEN=100
        ticks(15);
        total++; if ({X, Y, dx} !== {8'd151, 7'd99, 1'b1}) begin bad++; $display("FAIL at_right_face got=(%0d,%0d,dx%0d) exp=(151,99,dx1)", X, Y, dx); end
        ticks(1);
        total++; if ({hit2, hit1, dx} !== 3'b100) begin bad++; $display("FAIL hit2_pulse got=%b exp=100", {hit2, hit1, dx}); end
        total++; if ({X, Y} !== {8'd150, 7'd98}) begin bad++; $display("FAIL hit2_pos got=(%0d,%0d) exp=(150,98)", X, Y); end
        clk_cycle(1'b0, 1'b0);
        total++; if (hit2 !== 1'b0 || X !== 8'd150) begin bad++; $display("FAIL hit2_one_cycle got=hit2%0d x%0d exp=hit2 0 x150", hit2, X); end
    endtask

    task automatic test_p2_point;
        Y1 = 7'd53;  // Y+BALL_SIZE=53 is not strictly above 53: miss
        ticks(98);
        total++; if ({X, Y, dy} !== {8'd52, 7'd0, 1'b0}) begin bad++; $display("FAIL approach_top got=(%0d,%0d,dy%0d) exp=(52,0,dy0)", X, Y, dy); end
        ticks(1);
        total++; if ({X, Y, dy} !== {8'd51, 7'd1, 1'b1}) begin bad++; $display("FAIL top_bounce got=(%0d,%0d,dy%0d) exp=(51,1,dy1)", X, Y, dy); end
        ticks(47);
        total++; if ({X, Y} !== {8'd4, 7'd48}) begin bad++; $display("FAIL at_left_face got=(%0d,%0d) exp=(4,48)", X, Y); end
        ticks(1);
        total++; if ({X, hit1, dx} !== {8'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL left_miss got=x%0d hit1%0d dx%0d exp=x3 hit1 0 dx0", X, hit1, dx); end
        ticks(4);
        total++; if ({state, X, Y} !== {2'd2, 8'd0, 7'd52}) begin bad++; $display("FAIL p2_point_state got=st%0d (%0d,%0d) exp=st2 (0,52)", state, X, Y); end
        clk_cycle(1'b0, 1'b0);
        total++; if ({state, score1, score2, point} !== {2'd0, 4'd0, 4'd1, 1'b1}) begin bad++; $display("FAIL p2_scored got=st%0d s1=%0d s2=%0d pt%0d exp=st0 s1=0 s2=1 pt1", state, score1, score2, point); end
        total++; if ({X, Y} !== {8'd77, 7'd57}) begin bad++; $display("FAIL p2_recentre got=(%0d,%0d) exp=(77,57)", X, Y); end
        clk_cycle(1'b1, 1'b0);
        total++; if ({point, state, X} !== {1'b0, 2'd0, 8'd77}) begin bad++; $display("FAIL idle_tick_ignored got=pt%0d st%0d x%0d exp=pt0 st0 x77", point, state, X); end
    endtask

    task automatic test_hit1_p1_point;
        Y1 = 7'd76;  // Y=100 is the last row under Y1+PADDLE_LEN=101
        Y2 = 7'd0;
        clk_cycle(1'b0, 1'b1);
        total++; if ({state, dx, dy} !== {2'd1, 1'b0, 1'b1}) begin bad++; $display("FAIL serve_toward_p2 got=st%0d dx%0d dy%0d exp=st1 dx0 dy1", state, dx, dy); end
        ticks(73);
        total++; if ({X, Y} !== {8'd4, 7'd100}) begin bad++; $display("FAIL at_left_paddle got=(%0d,%0d) exp=(4,100)", X, Y); end
        ticks(1);
        total++; if ({hit1, hit2, dx, X, Y} !== {3'b101, 8'd5, 7'd99}) begin bad++; $display("FAIL hit1 got=h1%0d h2%0d dx%0d (%0d,%0d) exp=h1 1 h2 0 dx1 (5,99)", hit1, hit2, dx, X, Y); end
        ticks(146);
        total++; if ({X, Y} !== {8'd151, 7'd47}) begin bad++; $display("FAIL at_right_face2 got=(%0d,%0d) exp=(151,47)", X, Y); end
        ticks(1);
        total++; if ({X, hit2, dx} !== {8'd152, 1'b0, 1'b1}) begin bad++; $display("FAIL right_miss got=x%0d hit2%0d dx%0d exp=x152 hit2 0 dx1", X, hit2, dx); end
        ticks(4);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL p1_point_state got=%0d exp=2", state); end
        clk_cycle(1'b0, 1'b0);
        total++; if ({state, score1, score2, point} !== {2'd0, 4'd1, 4'd1, 1'b1}) begin bad++; $display("FAIL p1_scored got=st%0d s1=%0d s2=%0d pt%0d exp=st0 s1=1 s2=1 pt1", state, score1, score2, point); end
    endtask

    task automatic test_game_over;
        for (int k = 2; k <= 3; k++) begin
            clk_cycle(1'b0, 1'b1);
            total++; if ({state, dx} !== {2'd1, 1'b1}) begin bad++; $display("FAIL serve_after_p1 got=st%0d dx%0d exp=st1 dx1", state, dx); end
            ticks(78);
            total++; if ({X, Y} !== {8'd155, 7'd95}) begin bad++; $display("FAIL at_right_wall got=(%0d,%0d) exp=(155,95)", X, Y); end
            ticks(1);
            clk_cycle(1'b0, 1'b0);
            total++; if (score1 !== 4'(k)) begin bad++; $display("FAIL score1_count got=%0d exp=%0d", score1, k); end
        end
        total++; if ({state, game_over, point} !== {2'd3, 1'b1, 1'b1}) begin bad++; $display("FAIL over_entry got=st%0d go%0d pt%0d exp=st3 go1 pt1", state, game_over, point); end
        ticks(3);
        total++; if ({state, game_over, point, X, Y} !== {2'd3, 1'b1, 1'b0, 8'd77, 7'd57}) begin bad++; $display("FAIL over_ticks_ignored got=st%0d go%0d pt%0d (%0d,%0d) exp=st3 go1 pt0 (77,57)", state, game_over, point, X, Y); end
        clk_cycle(1'b0, 1'b1);
        total++; if ({state, game_over, score1, score2} !== {2'd0, 1'b0, 4'd0, 4'd0}) begin bad++; $display("FAIL new_game got=st%0d go%0d s1=%0d s2=%0d exp=st0 go0 s1=0 s2=0", state, game_over, score1, score2); end
        clk_cycle(1'b0, 1'b1);
        total++; if ({state, dx} !== {2'd1, 1'b1}) begin bad++; $display("FAIL new_game_serve got=st%0d dx%0d exp=st1 dx1", state, dx); end
    endtask

    initial begin
        test_reset;
        test_serve;
        test_reset_mid_play;
        test_wall_bounce;
        test_hit2;
        test_p2_point;
        test_hit1_p1_point;
        test_game_over;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
